// File: rtl/ex_mem_pipe_pkg.sv
// ex_mem_pipe_pkg: shared types and constants for the EX/MEM pipeline register.
//   stage_act_e  : per-edge action code produced by stage_ctl.
//   ZEROWORD, NOPREGADDR, WRITEDISABLE, ALUOP_WIDTH : common pipeline constants.
package ex_mem_pipe_pkg;

   localparam int   ALUOP_WIDTH  = 8;
   localparam int   ZEROWORD     = 0;
   localparam int   NOPREGADDR   = 0;
   localparam logic WRITEDISABLE = 1'b0;

   typedef enum logic [1:0] {
      ACT_ADVANCE = 2'd0,
      ACT_HOLD    = 2'd1,
      ACT_BUBBLE  = 2'd2,
      ACT_FLUSH   = 2'd3
   } stage_act_e;

endpackage

// File: rtl/ex_mem_pipe_stage_ctl.sv
// stage_ctl: combinational decode of pipeline control into one action code.
//   flush, stall_ex, stall_mem : inputs
//   act                        : ACT_FLUSH > ACT_BUBBLE > ACT_HOLD > ACT_ADVANCE
module stage_ctl
   import ex_mem_pipe_pkg::*;
(
   input  logic       flush,
   input  logic       stall_ex,
   input  logic       stall_mem,
   output stage_act_e act
);

   always_comb begin
      act = ACT_ADVANCE;
      if (flush)                      act = ACT_FLUSH;
      else if (stall_ex && !stall_mem) act = ACT_BUBBLE;
      else if (stall_mem)             act = ACT_HOLD;
   end

endmodule

// File: rtl/ex_mem_pipe.sv
// ex_mem_pipe: EX -> MEM pipeline register with flush / bubble / hold control.
//   clk, rst (async, active-low), stall_ex, stall_mem, flush : control
//   ex_*        : EX-stage instruction fields (valid, GPR wb, HI/LO wb, mem op)
//   ex_hilo_temp, ex_cnt : MADD/MSUB partial result and step counter
//   mem_*       : registered copies of the ex_* fields
//   hilo_temp_o, cnt_o   : accumulator state fed back to EX while EX is stalled
module ex_mem_pipe
   import ex_mem_pipe_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5,
   parameter int ALUOP_W   = ALUOP_WIDTH,
   parameter int CNT_W     = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall_ex,
   input  logic                 stall_mem,
   input  logic                 flush,
   input  logic                 ex_valid,
   input  logic [REGADDR_W-1:0] ex_wd,
   input  logic                 ex_wreg,
   input  logic [DATA_W-1:0]    ex_wdata,
   input  logic [DATA_W-1:0]    ex_hi,
   input  logic [DATA_W-1:0]    ex_lo,
   input  logic                 ex_whilo,
   input  logic [ALUOP_W-1:0]   ex_aluop,
   input  logic [DATA_W-1:0]    ex_mem_addr,
   input  logic [DATA_W-1:0]    ex_reg2,
   input  logic [2*DATA_W-1:0]  ex_hilo_temp,
   input  logic [CNT_W-1:0]     ex_cnt,
   output logic                 mem_valid,
   output logic [REGADDR_W-1:0] mem_wd,
   output logic                 mem_wreg,
   output logic [DATA_W-1:0]    mem_wdata,
   output logic [DATA_W-1:0]    mem_hi,
   output logic [DATA_W-1:0]    mem_lo,
   output logic                 mem_whilo,
   output logic [ALUOP_W-1:0]   mem_aluop,
   output logic [DATA_W-1:0]    mem_mem_addr,
   output logic [DATA_W-1:0]    mem_reg2,
   output logic [2*DATA_W-1:0]  hilo_temp_o,
   output logic [CNT_W-1:0]     cnt_o
);

   localparam logic [DATA_W-1:0]    ZW = DATA_W'(ZEROWORD);
   localparam logic [REGADDR_W-1:0] NOP_WD = REGADDR_W'(NOPREGADDR);

   stage_act_e act;

   stage_ctl u_ctl (
      .flush     (flush),
      .stall_ex  (stall_ex),
      .stall_mem (stall_mem),
      .act       (act)
   );

   logic                 valid_d,     valid_q;
   logic [REGADDR_W-1:0] wd_d,        wd_q;
   logic                 wreg_d,      wreg_q;
   logic [DATA_W-1:0]    wdata_d,     wdata_q;
   logic [DATA_W-1:0]    hi_d,        hi_q;
   logic [DATA_W-1:0]    lo_d,        lo_q;
   logic                 whilo_d,     whilo_q;
   logic [ALUOP_W-1:0]   aluop_d,     aluop_q;
   logic [DATA_W-1:0]    mem_addr_d,  mem_addr_q;
   logic [DATA_W-1:0]    reg2_d,      reg2_q;
   logic [2*DATA_W-1:0]  hilo_temp_d, hilo_temp_q;
   logic [CNT_W-1:0]     cnt_d,       cnt_q;

   always_comb begin
      // default: HOLD
      valid_d     = valid_q;
      wd_d        = wd_q;
      wreg_d      = wreg_q;
      wdata_d     = wdata_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      whilo_d     = whilo_q;
      aluop_d     = aluop_q;
      mem_addr_d  = mem_addr_q;
      reg2_d      = reg2_q;
      hilo_temp_d = hilo_temp_q;
      cnt_d       = cnt_q;
      case (act)
         ACT_FLUSH, ACT_BUBBLE: begin
            valid_d     = 1'b0;
            wd_d        = NOP_WD;
            wreg_d      = WRITEDISABLE;
            wdata_d     = ZW;
            hi_d        = ZW;
            lo_d        = ZW;
            whilo_d     = WRITEDISABLE;
            aluop_d     = '0;
            mem_addr_d  = ZW;
            reg2_d      = ZW;
            hilo_temp_d = '0;
            cnt_d       = '0;
            // A bubble keeps the MADD/MSUB accumulator cycling back to EX.
            if (act == ACT_BUBBLE) begin
               hilo_temp_d = ex_hilo_temp;
               cnt_d       = ex_cnt;
            end
         end
         ACT_ADVANCE: begin
            valid_d     = ex_valid;
            wd_d        = ex_wd;
            wreg_d      = ex_wreg & ex_valid;
            wdata_d     = ex_wdata;
            hi_d        = ex_hi;
            lo_d        = ex_lo;
            whilo_d     = ex_whilo & ex_valid;
            aluop_d     = ex_aluop;
            mem_addr_d  = ex_mem_addr;
            reg2_d      = ex_reg2;
            // Instruction left EX: the accumulator must not leak forward.
            hilo_temp_d = '0;
            cnt_d       = '0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q     <= 1'b0;
         wd_q        <= NOP_WD;
         wreg_q      <= WRITEDISABLE;
         wdata_q     <= ZW;
         hi_q        <= ZW;
         lo_q        <= ZW;
         whilo_q     <= WRITEDISABLE;
         aluop_q     <= '0;
         mem_addr_q  <= ZW;
         reg2_q      <= ZW;
         hilo_temp_q <= '0;
         cnt_q       <= '0;
      end else begin
         valid_q     <= valid_d;
         wd_q        <= wd_d;
         wreg_q      <= wreg_d;
         wdata_q     <= wdata_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         whilo_q     <= whilo_d;
         aluop_q     <= aluop_d;
         mem_addr_q  <= mem_addr_d;
         reg2_q      <= reg2_d;
         hilo_temp_q <= hilo_temp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign mem_valid    = valid_q;
   assign mem_wd       = wd_q;
   assign mem_wreg     = wreg_q;
   assign mem_wdata    = wdata_q;
   assign mem_hi       = hi_q;
   assign mem_lo       = lo_q;
   assign mem_whilo    = whilo_q;
   assign mem_aluop    = aluop_q;
   assign mem_mem_addr = mem_addr_q;
   assign mem_reg2     = reg2_q;
   assign hilo_temp_o  = hilo_temp_q;
   assign cnt_o        = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb_ex_mem_pipe: scoreboard bench for ex_mem_pipe (default parameters).
module tb_ex_mem_pipe;

   localparam int DW = 32;
   localparam int RW = 5;
   localparam int AW = 8;
   localparam int CW = 2;

   typedef struct packed {
      logic          valid;
      logic [RW-1:0] wd;
      logic          wreg;
      logic [DW-1:0] wdata;
      logic [DW-1:0] hi;
      logic [DW-1:0] lo;
      logic          whilo;
      logic [AW-1:0] aluop;
      logic [DW-1:0] addr;
      logic [DW-1:0] reg2;
      logic [2*DW-1:0] hilo;
      logic [CW-1:0] cnt;
   } fld_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stall_ex = 1'b0, stall_mem = 1'b0, flush = 1'b0;
   fld_t in_f = '0;
   fld_t got;

   logic          mem_valid, mem_wreg, mem_whilo;
   logic [RW-1:0] mem_wd;
   logic [DW-1:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
   logic [AW-1:0] mem_aluop;
   logic [2*DW-1:0] hilo_temp_o;
   logic [CW-1:0] cnt_o;

   int n_vec = 0;
   int n_bad = 0;
   fld_t sb[$];
   fld_t model_q = '0;

   always #5 clk = ~clk;

   ex_mem_pipe #(.DATA_W(DW), .REGADDR_W(RW), .ALUOP_W(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
      .ex_valid(in_f.valid), .ex_wd(in_f.wd), .ex_wreg(in_f.wreg), .ex_wdata(in_f.wdata),
      .ex_hi(in_f.hi), .ex_lo(in_f.lo), .ex_whilo(in_f.whilo), .ex_aluop(in_f.aluop),
      .ex_mem_addr(in_f.addr), .ex_reg2(in_f.reg2), .ex_hilo_temp(in_f.hilo), .ex_cnt(in_f.cnt),
      .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
      .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
   );

   assign got = '{mem_valid, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo,
                  mem_aluop, mem_mem_addr, mem_reg2, hilo_temp_o, cnt_o};

   // stall_mem without stall_ex is not a legal pipeline state.
   always @(posedge clk)
      if (rst && !flush)
         assert (!(stall_mem && !stall_ex)) else $error("illegal stall_mem=1 with stall_ex=0");

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string ctx, input fld_t o, input fld_t e);
      chk({ctx, ".valid"}, 64'(o.valid), 64'(e.valid));
      chk({ctx, ".wd"},    64'(o.wd),    64'(e.wd));
      chk({ctx, ".wreg"},  64'(o.wreg),  64'(e.wreg));
      chk({ctx, ".wdata"}, 64'(o.wdata), 64'(e.wdata));
      chk({ctx, ".hi"},    64'(o.hi),    64'(e.hi));
      chk({ctx, ".lo"},    64'(o.lo),    64'(e.lo));
      chk({ctx, ".whilo"}, 64'(o.whilo), 64'(e.whilo));
      chk({ctx, ".aluop"}, 64'(o.aluop), 64'(e.aluop));
      chk({ctx, ".addr"},  64'(o.addr),  64'(e.addr));
      chk({ctx, ".reg2"},  64'(o.reg2),  64'(e.reg2));
      chk({ctx, ".hilo"},  o.hilo,       e.hilo);
      chk({ctx, ".cnt"},   64'(o.cnt),   64'(e.cnt));
   endtask

   function automatic fld_t model(input fld_t cur, input logic fl, input logic se,
                                  input logic sm, input fld_t i);
      fld_t n;
      if (fl) n = '0;
      else if (sm) n = cur;
      else if (se) begin
         n = '0;
         n.hilo = i.hilo;
         n.cnt  = i.cnt;
      end else begin
         n = i;
         n.wreg  = i.wreg & i.valid;
         n.whilo = i.whilo & i.valid;
         n.hilo  = '0;
         n.cnt   = '0;
      end
      return n;
   endfunction

   function automatic fld_t rnd_fld();
      fld_t r;
      r.valid = 1'($urandom); r.wd = RW'($urandom); r.wreg = 1'($urandom);
      r.wdata = $urandom; r.hi = $urandom; r.lo = $urandom; r.whilo = 1'($urandom);
      r.aluop = AW'($urandom); r.addr = $urandom; r.reg2 = $urandom;
      r.hilo = {$urandom, $urandom}; r.cnt = CW'($urandom);
      return r;
   endfunction

   // Called at a negedge: drive, predict, clock, compare.
   task automatic step(input string ctx, input logic fl, input logic se, input logic sm,
                       input fld_t i);
      fld_t e;
      flush = fl; stall_ex = se; stall_mem = sm; in_f = i;
      sb.push_back(model(model_q, fl, se, sm, i));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_all(ctx, got, e);
      model_q = e;
      @(negedge clk);
   endtask

   // Pull reset mid-cycle and confirm outputs clear without a clock edge.
   task automatic async_reset(input string ctx);
      #2 rst = 1'b0;
      #1 chk_all(ctx, got, '0);
      model_q = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      fld_t f;
      #2 chk_all("reset", got, '0);
      @(negedge clk);
      rst = 1'b1;

      // plain advance
      f = '0; f.wd = 5'd5; f.wreg = 1'b1; f.valid = 1'b1; f.wdata = 32'hDEADBEEF;
      step("advance", 1'b0, 1'b0, 1'b0, f);

      // async reset while outputs are non-zero
      async_reset("rst_mid");

      // bubble carries the accumulator, kills the writeback
      f = '0; f.valid = 1'b1; f.wreg = 1'b1; f.cnt = 2'd1; f.hilo = 64'h0000_0001_0000_0002;
      step("bubble", 1'b0, 1'b1, 1'b0, f);
      f.cnt = 2'd2; f.hilo = 64'h0000_0003_0000_0004;
      step("bubble2", 1'b0, 1'b1, 1'b0, f);
      // advance clears accumulator
      f = rnd_fld();
      step("adv_clr", 1'b0, 1'b0, 1'b0, f);

      // hold with changing inputs
      f = '0; f.valid = 1'b1; f.wdata = 32'h12;
      step("pre_hold", 1'b0, 1'b0, 1'b0, f);
      for (int k = 0; k < 3; k++) begin
         step($sformatf("hold%0d", k), 1'b0, 1'b1, 1'b1, rnd_fld());
         chk("hold_wdata", 64'(mem_wdata), 64'h12);
      end

      // flush wins over both stalls
      step("pre_flush", 1'b0, 1'b0, 1'b0, rnd_fld());
      step("flush", 1'b1, 1'b1, 1'b1, rnd_fld());

      // valid gating
      f = rnd_fld(); f.valid = 1'b0; f.wreg = 1'b1; f.whilo = 1'b1;
      step("vgate", 1'b0, 1'b0, 1'b0, f);

      // reset during a stalled MADD discards the accumulator
      f = '0; f.cnt = 2'd3; f.hilo = 64'hCAFE_0000_BEEF_0001;
      step("madd", 1'b0, 1'b1, 1'b0, f);
      async_reset("rst_madd");
      step("hold_after_rst", 1'b0, 1'b1, 1'b1, rnd_fld());

      // random legal traffic
      for (int k = 0; k < 200; k++) begin
         logic fl, se, sm;
         fl = ($urandom_range(0, 9) == 0);
         se = 1'($urandom);
         sm = se & 1'($urandom);
         step("rand", fl, se, sm, rnd_fld());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: run did not complete");
      $fatal(1, "timeout");
   end

endmodule
